// File: rtl/spin_rotator_2_pkg.sv
// spin_rotator_2_pkg: shared widths, twiddle fraction bits and the W8^k twiddle constants
package spin_rotator_2_pkg;
   localparam int DATA_W_DEF = 16;
   localparam int TW_W_DEF   = 12;
   localparam int TW_FRAC    = 7;
   // W8^k in Q1.7, 127 = 1.0, k = 0..7
   localparam int TW_RE [8] = '{127, 90, 0, -90, -127, -90, 0, 90};
   localparam int TW_IM [8] = '{0, -90, -127, -90, 0, 90, 127, 90};
endpackage

// File: rtl/spin_lut_2.sv
// spin_lut_2: combinational twiddle lookup, (k, inv) -> W8^k or conj(W8^k)
//  k      in   3     frame position
//  inv    in   1     1 = conjugate (IFFT direction)
//  tw_re  out  TW_W  twiddle real part, signed Q1.7
//  tw_im  out  TW_W  twiddle imaginary part, signed Q1.7
module spin_lut_2
   import spin_rotator_2_pkg::*;
#(
   parameter int TW_W = TW_W_DEF
) (
   input  logic [2:0]             k,
   input  logic                   inv,
   output logic signed [TW_W-1:0] tw_re,
   output logic signed [TW_W-1:0] tw_im
);
   always_comb begin
      tw_re = TW_W'(TW_RE[k]);
      tw_im = inv ? TW_W'(-TW_IM[k]) : TW_W'(TW_IM[k]);
   end
endmodule

// File: rtl/spin_rotator_2.sv
// spin_rotator_2: 2-stage streaming W8^k twiddle rotator with valid/ready and saturation
//  clk, rst_n            clock, asynchronous active-low reset
//  in_valid/in_ready     input handshake
//  in_first              sample is k=0 of a new frame
//  in_inv                1 = conjugate twiddle (IFFT)
//  in_re/in_im           signed input sample
//  out_valid/out_ready   output handshake
//  out_re/out_im         rotated, saturated sample
//  out_last              output is k=7 of its frame
//  out_sat               either part was clipped
//  SPIN_ROUND_EN         define to round half up before the Q1.7 rescale instead of flooring
module spin_rotator_2
   import spin_rotator_2_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int TW_W   = TW_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_first,
   input  logic                     in_inv,
   input  logic signed [DATA_W-1:0] in_re,
   input  logic signed [DATA_W-1:0] in_im,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_re,
   output logic signed [DATA_W-1:0] out_im,
   output logic                     out_last,
   output logic                     out_sat
);
   localparam int P = DATA_W + TW_W;
`ifdef SPIN_ROUND_EN
   localparam logic signed [P:0] RND = (P+1)'(1 << (TW_FRAC - 1));
`else
   localparam logic signed [P:0] RND = '0;
`endif
   localparam logic signed [P:0] MAX_V = (P+1)'((1 << (DATA_W - 1)) - 1);
   localparam logic signed [P:0] MIN_V = ~MAX_V;
   logic                     en, acc;
   logic [2:0]               k, k_eff;
   logic signed [TW_W-1:0]   tw_re, tw_im;
   logic signed [P-1:0]      ac, bd, ad, bc;
   logic                     s1_valid, s1_last;
   logic signed [P:0]        re_s, im_s;
   logic                     re_hi, re_lo, im_hi, im_lo;
   logic signed [DATA_W-1:0] re_c, im_c;
   // the whole pipe advances only when the output register can be overwritten
   assign en       = !out_valid || out_ready;
   assign in_ready = en;
   assign acc      = in_valid && en;
   assign k_eff    = in_first ? 3'd0 : k;
   spin_lut_2 #(.TW_W(TW_W)) u_lut (
      .k     (k_eff),
      .inv   (in_inv),
      .tw_re (tw_re),
      .tw_im (tw_im)
   );
   always_comb begin
      re_s  = ((P+1)'(ac) - (P+1)'(bd) + RND) >>> TW_FRAC;
      im_s  = ((P+1)'(ad) + (P+1)'(bc) + RND) >>> TW_FRAC;
      re_hi = re_s > MAX_V;
      re_lo = re_s < MIN_V;
      im_hi = im_s > MAX_V;
      im_lo = im_s < MIN_V;
      re_c  = re_hi ? MAX_V[DATA_W-1:0] : re_lo ? MIN_V[DATA_W-1:0] : re_s[DATA_W-1:0];
      im_c  = im_hi ? MAX_V[DATA_W-1:0] : im_lo ? MIN_V[DATA_W-1:0] : im_s[DATA_W-1:0];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k         <= '0;
         ac        <= '0;
         bd        <= '0;
         ad        <= '0;
         bc        <= '0;
         s1_valid  <= 1'b0;
         s1_last   <= 1'b0;
         out_valid <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
         out_last  <= 1'b0;
         out_sat   <= 1'b0;
      end else begin
         if (acc) begin
            k       <= k_eff + 3'd1;
            ac      <= P'(in_re) * P'(tw_re);
            bd      <= P'(in_im) * P'(tw_im);
            ad      <= P'(in_re) * P'(tw_im);
            bc      <= P'(in_im) * P'(tw_re);
            s1_last <= k_eff == 3'd7;
         end
         if (en) begin
            s1_valid  <= acc;
            out_valid <= s1_valid;
         end
         // data registers only load real samples, so they hold while out_valid is low
         if (en && s1_valid) begin
            out_re   <= re_c;
            out_im   <= im_c;
            out_last <= s1_last;
            out_sat  <= re_hi || re_lo || im_hi || im_lo;
         end
      end
   end
endmodule

// File: tb/tb_spin_rotator_2.sv
// tb_spin_rotator_2: randomized and directed checks of spin_rotator_2 against a complex-multiply model
module tb_spin_rotator_2;
   typedef struct {
      longint re;
      longint im;
      bit     last;
      bit     sat;
   } exp_t;
   logic               clk = 1'b0;
   logic               rst_n = 1'b1;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic               in_first = 1'b0;
   logic               in_inv = 1'b0;
   logic signed [15:0] in_re = '0;
   logic signed [15:0] in_im = '0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic signed [15:0] out_re;
   logic signed [15:0] out_im;
   logic               out_last;
   logic               out_sat;
   int                 checks = 0;
   int                 passes = 0;
   int                 fails = 0;
   int                 mk = 0;
   int                 nout = 0;
   int                 nlast = 0;
   exp_t               q[$];
   int                 twr [8] = '{127, 90, 0, -90, -127, -90, 0, 90};
   int                 twi [8] = '{0, -90, -127, -90, 0, 90, 127, 90};
   spin_rotator_2 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_first  (in_first),
      .in_inv    (in_inv),
      .in_re     (in_re),
      .in_im     (in_im),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_re    (out_re),
      .out_im    (out_im),
      .out_last  (out_last),
      .out_sat   (out_sat)
   );
   always #5 clk = ~clk;
   task automatic chk(string tag, logic signed [63:0] got, logic signed [63:0] exp);
      checks++;
      assert (got === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   // Q1.7 rescale: divide by 128 rounding toward minus infinity (optionally after +0.5)
   function automatic longint scale(longint v);
      longint d;
`ifdef SPIN_ROUND_EN
      v = v + 64;
`endif
      d = v / 128;
      if (v < 0 && d * 128 != v) d = d - 1;
      return d;
   endfunction
   function automatic exp_t model(longint a, longint b, int k, bit inv);
      exp_t   e;
      longint c, d, r, i;
      c = twr[k];
      d = inv ? -twi[k] : twi[k];
      r = scale(a * c - b * d);
      i = scale(a * d + b * c);
      e.sat  = r > 32767 || r < -32768 || i > 32767 || i < -32768;
      e.re   = r > 32767 ? 32767 : r < -32768 ? -32768 : r;
      e.im   = i > 32767 ? 32767 : i < -32768 ? -32768 : i;
      e.last = k == 7;
      return e;
   endfunction
   // one clock: check any output handshake, record any accepted input, return just after the edge
   task automatic tick();
      exp_t e;
      int   ke;
      @(negedge clk);
      if (out_valid && out_ready) begin
         if (q.size() == 0) chk("unexpected_out", out_valid, 0);
         else begin
            e = q.pop_front();
            chk("out_re", out_re, e.re);
            chk("out_im", out_im, e.im);
            chk("out_last", out_last, e.last);
            chk("out_sat", out_sat, e.sat);
            nout++;
            if (out_last) nlast++;
         end
      end
      if (rst_n && in_valid && in_ready) begin
         ke = in_first ? 0 : mk;
         q.push_back(model(in_re, in_im, ke, in_inv));
         mk = (ke + 1) % 8;
      end
      @(posedge clk);
      #1;
   endtask
   task automatic send(bit f, bit inv, int re, int im);
      in_valid = 1'b1;
      in_first = f;
      in_inv   = inv;
      in_re    = 16'(re);
      in_im    = 16'(im);
      tick();
      in_valid = 1'b0;
      in_first = 1'b0;
   endtask
   task automatic rand_in(bit f);
      in_first = f;
      in_inv   = 1'($urandom);
      in_re    = ($urandom % 2) ? 16'($urandom) : 16'($urandom_range(4000) - 2000);
      in_im    = ($urandom % 2) ? 16'($urandom) : 16'($urandom_range(4000) - 2000);
   endtask
   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && q.size() > 0; i++) tick();
      tick();
      chk("drain_empty", q.size(), 0);
   endtask
   initial begin
      int               n0, l0;
      logic signed [15:0] h_re, h_im;
      logic               h_last;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_re", out_re, 0);
      chk("rst_out_im", out_im, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_sat", out_sat, 0);
      rst_n = 1'b1;
      tick();
      chk("rst_in_ready", in_ready, 1);
      // 1: k=0 passes through scaled by 127/128, two cycles after accept
      send(1, 0, 1000, 0);
      chk("t1_lat_not_yet", out_valid, 0);
      tick();
      chk("t1_valid", out_valid, 1);
      chk("t1_re", out_re, 992);
      chk("t1_im", out_im, 0);
      chk("t1_sat", out_sat, 0);
      tick();
      // 2: k=1
      send(1, 0, 0, 0);
      send(0, 0, 1000, 1000);
      tick();
      chk("t2_re", out_re, 1406);
      chk("t2_im", out_im, 0);
      tick();
      // 3: k=2, both directions
      send(1, 0, 0, 0);
      send(0, 0, 0, 0);
      send(0, 0, 1000, 0);
      tick();
      chk("t3_re", out_re, 0);
`ifdef SPIN_ROUND_EN
      chk("t3_im", out_im, -992);
`else
      chk("t3_im", out_im, -993);
`endif
      tick();
      send(1, 1, 0, 0);
      send(0, 1, 0, 0);
      send(0, 1, 1000, 0);
      tick();
      chk("t3_inv_re", out_re, 0);
      chk("t3_inv_im", out_im, 992);
      tick();
      // 4: saturation
      send(1, 0, 0, 0);
      send(0, 0, 32767, 32767);
      tick();
      chk("t4_re", out_re, 32767);
      chk("t4_im", out_im, 0);
      chk("t4_sat", out_sat, 1);
      tick();
      drain();
      // 5: 10 back-to-back samples, full throughput
      n0 = nout;
      l0 = nlast;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         rand_in(i == 0);
         chk("t5_in_ready", in_ready, 1);
         tick();
         if (i >= 1) chk("t5_stream_valid", out_valid, 1);
      end
      in_valid = 1'b0;
      in_first = 1'b0;
      tick();
      tick();
      tick();
      chk("t5_count", nout - n0, 10);
      chk("t5_last_count", nlast - l0, 1);
      drain();
      // 6: 5-cycle stall with a full pipe, then in_first mid-frame
      send(1, 0, 0, 0);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      rand_in(0);
      tick();
      rand_in(0);
      tick();
      chk("t6_full", out_valid, 1);
      h_re   = out_re;
      h_im   = out_im;
      h_last = out_last;
      for (int i = 0; i < 5; i++) begin
         rand_in(0);
         tick();
         chk("t6_in_ready", in_ready, 0);
         chk("t6_hold_valid", out_valid, 1);
         chk("t6_hold_re", out_re, h_re);
         chk("t6_hold_im", out_im, h_im);
         chk("t6_hold_last", out_last, h_last);
      end
      out_ready = 1'b1;
      rand_in(0);
      tick();
      send(1, 0, 1000, 0);
      tick();
      tick();
      chk("t6_first_re", out_re, 992);
      chk("t6_first_im", out_im, 0);
      drain();
      // random traffic with random backpressure and frame restarts
      for (int i = 0; i < 300; i++) begin
         in_valid  = ($urandom % 4) != 0;
         out_ready = ($urandom % 4) != 0;
         rand_in(($urandom % 8) == 0);
         tick();
      end
      in_first = 1'b0;
      drain();
      // reset mid-operation discards in-flight samples and restarts k
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         rand_in(i == 0);
         tick();
      end
      in_valid = 1'b0;
      in_first = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 1);
      q.delete();
      mk = 0;
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("post_rst_idle", out_valid, 0);
      end
      send(0, 0, 1000, 0);
      tick();
      chk("post_rst_k0_re", out_re, 992);
      chk("post_rst_k0_im", out_im, 0);
      drain();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
